// File: rtl/alu_pkg.sv
// Shared ALU control encodings and the multiplier FSM state type.
// The datapath ALU decoder uses the same control constants.
package alu_pkg;

   localparam logic [3:0] ALU_AND   = 4'b0000;
   localparam logic [3:0] ALU_OR    = 4'b0001;
   localparam logic [3:0] ALU_ADD   = 4'b0010;
   localparam logic [3:0] ALU_SUB   = 4'b0110;
   localparam logic [3:0] ALU_PASSB = 4'b0111;

   typedef enum logic [1:0] {
      IDLE,
      CHECK,
      ITER,
      DONE
   } mul_state_t;

endpackage

// File: rtl/alu_mul_seq_if.sv
// Operand/result bus between an initiator (the multiplier) and the shared
// combinational ALU that responds to it.
interface alu_mul_seq_if #(
   parameter int N = 64
);

   logic [N-1:0] alu_a;
   logic [N-1:0] alu_b;
   logic [3:0]   alu_ctrl;
   logic [N-1:0] alu_result;
   logic         alu_zero;

   modport master (
      output alu_a, alu_b, alu_ctrl,
      input  alu_result, alu_zero
   );

   modport slave (
      input  alu_a, alu_b, alu_ctrl,
      output alu_result, alu_zero
   );

endinterface

// File: rtl/alu_mul_seq.sv
// Iterative shift-and-add multiplier that borrows the datapath ALU for its
// additions; produces the low N bits of op_a*op_b (sign-agnostic).
module alu_mul_seq
   import alu_pkg::*;
#(
   parameter int N = 64
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [N-1:0]  op_a,
   input  logic [N-1:0]  op_b,
   output logic          busy,
   output logic          done,
   output logic [N-1:0]  product,
   alu_mul_seq_if.master alu
);

   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   mul_state_t    state_q, state_d;
   logic [N-1:0]  mcand_q, mcand_d;
   logic [N-1:0]  mplier_q, mplier_d;
   logic [N-1:0]  acc_q, acc_d;
   logic [N-1:0]  product_q, product_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic [N-1:0]  alu_a_c, alu_b_c;
   logic [3:0]    alu_ctrl_c;

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
      state_d    = state_q;
      mcand_d    = mcand_q;
      mplier_d   = mplier_q;
      acc_d      = acc_q;
      cnt_d      = cnt_q;
      product_d  = product_q;
      alu_a_c    = '0;
      alu_b_c    = '0;
      alu_ctrl_c = ALU_AND;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               mcand_d  = op_a;
               mplier_d = op_b;
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = CHECK;
            end
         end

         // AND of the multiplier with itself lets the ALU's zero flag detect op_b==0.
         CHECK: begin
            alu_a_c = mplier_q;
            alu_b_c = mplier_q;
            if (alu.alu_zero) begin
               acc_d     = '0;
               product_d = '0;
               state_d   = DONE;
            end else begin
               state_d = ITER;
            end
         end

         ITER: begin
            alu_a_c    = mcand_q;
            alu_b_c    = acc_q;
            alu_ctrl_c = mplier_q[0] ? ALU_ADD : ALU_PASSB;
            acc_d      = alu.alu_result;
            mcand_d    = mcand_q << 1;
            mplier_d   = mplier_q >> 1;
            cnt_d      = cnt_q + CW'(1);
            // Stop early once no multiplier bits remain, or after the N-th step.
            if ((mplier_q >> 1) == '0 || cnt_q == CNT_LAST) begin
               product_d = alu.alu_result;
               state_d   = DONE;
            end
         end

         DONE: state_d = IDLE;

         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments; async reset clears every register, including the in-flight datapath.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
      end
   end

   assign busy         = (state_q != IDLE);
   assign done         = (state_q == DONE);
   assign product      = product_q;
   assign alu.alu_a    = alu_a_c;
   assign alu.alu_b    = alu_b_c;
   assign alu.alu_ctrl = alu_ctrl_c;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq paired with a behavioural 64-bit ALU; expected
// products go through a scoreboard queue and are popped on each done pulse.
module tb_alu_mul_seq;
   import alu_pkg::*;

   localparam int N = 64;

   logic         clk;
   logic         reset;
   logic         start;
   logic [N-1:0] op_a;
   logic [N-1:0] op_b;
   logic         busy;
   logic         done;
   logic [N-1:0] product;

   int checks = 0;
   int errors = 0;
   logic [N-1:0] exp_q[$];

   alu_mul_seq_if #(.N(N)) bus ();

   alu_mul_seq #(.N(N)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .op_a    (op_a),
      .op_b    (op_b),
      .busy    (busy),
      .done    (done),
      .product (product),
      .alu     (bus.master)
   );

   // Existing datapath ALU, combinational.
   always_comb begin
      bus.alu_result = '0;
      case (bus.alu_ctrl)
         ALU_AND:   bus.alu_result = bus.alu_a & bus.alu_b;
         ALU_OR:    bus.alu_result = bus.alu_a | bus.alu_b;
         ALU_ADD:   bus.alu_result = bus.alu_a + bus.alu_b;
         ALU_SUB:   bus.alu_result = bus.alu_a - bus.alu_b;
         ALU_PASSB: bus.alu_result = bus.alu_b;
         default:   bus.alu_result = '0;
      endcase
      bus.alu_zero = (bus.alu_result == '0);
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout, required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int msb_k(input logic [N-1:0] b);
      int k = 0;
      for (int i = 0; i < N; i++) if (b[i]) k = i + 1;
      return k;
   endfunction

   // Wait (bounded) for done; n counts edges since the call.
   task automatic wait_done(input int limit, output int n);
      n = 0;
      while (done !== 1'b1 && n < limit) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input string tag);
      int k;
      int n;
      logic [N-1:0] exp_p;
      k = msb_k(b);
      exp_q.push_back(a * b);
      @(negedge clk);
      start = 1'b1; op_a = a; op_b = b;
      @(posedge clk); #1;
      start = 1'b0; op_a = ~a; op_b = ~b;
      check({tag, "_busy_check"}, N'(busy), N'(1));
      check({tag, "_ctrl_check"}, N'(bus.alu_ctrl), N'(ALU_AND));
      check({tag, "_alua_check"}, bus.alu_a, b);
      n = 0;
      while (done !== 1'b1 && n < k + 4) begin
         @(posedge clk); #1;
         n++;
         if (n <= k && done !== 1'b1)
            check($sformatf("%s_ctrl_iter%0d", tag, n), N'(bus.alu_ctrl),
                  N'(b[n-1] ? ALU_ADD : ALU_PASSB));
      end
      check({tag, "_latency"}, N'(n), N'(k + 1));
      check({tag, "_done"}, N'(done), N'(1));
      exp_p = exp_q.pop_front();
      check({tag, "_product"}, product, exp_p);
      check({tag, "_ctrl_done"}, N'(bus.alu_ctrl), N'(ALU_AND));
      check({tag, "_alua_done"}, bus.alu_a, '0);
      @(posedge clk); #1;
      check({tag, "_busy_after"}, N'(busy), N'(0));
      check({tag, "_done_after"}, N'(done), N'(0));
      check({tag, "_product_hold"}, product, exp_p);
   endtask

   initial begin
      int n;
      reset = 1'b0;
      start = 1'b0;
      op_a  = '0;
      op_b  = '0;
      #12;
      check("reset_busy", N'(busy), N'(0));
      check("reset_done", N'(done), N'(0));
      check("reset_product", product, '0);
      check("reset_ctrl", N'(bus.alu_ctrl), N'(ALU_AND));
      check("reset_alua", bus.alu_a, '0);
      @(negedge clk);
      reset = 1'b1;

      do_op(64'd6, 64'd7, "mul6x7");
      do_op(64'd5, 64'd0, "mul5x0");
      do_op(64'hFFFF_FFFF_FFFF_FFFD, 64'd4, "neg3x4");
      do_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, "ones");
      do_op(64'h1234_5678_9ABC_DEF0, 64'h8000_0000_0000_0001, "msb");

      // Abandon 3*9 with an asynchronous reset mid-ITER; ignored start during ITER.
      do_op(64'd6, 64'd7, "pre_reset");
      @(negedge clk);
      start = 1'b1; op_a = 64'd3; op_b = 64'd9;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      start = 1'b1; op_a = 64'd100;
      @(posedge clk); #1;
      start = 1'b0;
      check("iter_busy", N'(busy), N'(1));
      #2;
      reset = 1'b0;
      #1;
      check("async_busy", N'(busy), N'(0));
      check("async_done", N'(done), N'(0));
      check("async_product", product, '0);
      @(posedge clk); #1;
      reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         check($sformatf("no_done_%0d", i), N'(done), N'(0));
      end
      check("post_reset_busy", N'(busy), N'(0));
      do_op(64'd2, 64'd3, "after_reset");

      // start held high: back-to-back 2*3 then 4*5.
      exp_q.push_back(64'd6);
      exp_q.push_back(64'd20);
      @(negedge clk);
      start = 1'b1; op_a = 64'd2; op_b = 64'd3;
      @(posedge clk); #1;
      op_a = 64'd4; op_b = 64'd5;
      wait_done(10, n);
      check("held1_latency", N'(n), N'(3));
      check("held1_product", product, exp_q.pop_front());
      @(posedge clk); #1;
      check("held_idle_busy", N'(busy), N'(0));
      @(posedge clk); #1;
      check("held2_accept_busy", N'(busy), N'(1));
      start = 1'b0;
      wait_done(10, n);
      check("held2_latency", N'(n), N'(4));
      check("held2_product", product, exp_q.pop_front());

      check("scoreboard_empty", N'(exp_q.size()), N'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Iterative shift-and-add multiplier that drives a shared combinational ALU over its a/b/ALUcontrol/result/zero interface. It is the initiator side of that interface; the ALU is the responder.
- Sits beside the datapath ALU and implements MUL: the low N bits of op_a*op_b, so the result is valid for both signed and unsigned operands.
- The parent muxes alu_a/alu_b/alu_ctrl onto the ALU while busy=1 and feeds alu_result/alu_zero back.

Parameters:
N, 64, operand/product width (>=2)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  request; sampled only in IDLE
op_a  in  N  multiplicand, captured on the accepting edge
op_b  in  N  multiplier, captured on the accepting edge
busy  out  1  high from the accepting edge until the edge that leaves DONE
done  out  1  one-cycle pulse; product valid
product  out  N  low N bits of op_a*op_b; holds until the next accept
alu_a  out  N  ALU operand a
alu_b  out  N  ALU operand b
alu_ctrl  out  4  ALU control code
alu_result  in  N  ALU result, combinational response
alu_zero  in  1  ALU zero flag

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy=0, done=0, product=0; internal mcand/mplier/acc/cnt=0. An operation in flight is abandoned with no done pulse.
- States: IDLE, CHECK, ITER, DONE. Outputs are Moore, decoded from state and registers.
- IDLE: alu_a=0, alu_b=0, alu_ctrl=ALU_AND.
  - If start=1 at the edge: mcand<=op_a, mplier<=op_b, acc<=0, cnt<=0, go to CHECK.
- CHECK: alu_a=mplier, alu_b=mplier, alu_ctrl=ALU_AND (4'b0000).
  - If alu_zero=1: go to DONE with acc=0.
  - Otherwise go to ITER.
- ITER: alu_a=mcand, alu_b=acc.
  - alu_ctrl=ALU_ADD (4'b0010) if mplier[0]=1, else ALU_PASSB (4'b0111).
  - At the edge: acc<=alu_result, mcand<=mcand<<1, mplier<=mplier>>1, cnt<=cnt+1.
  - Go to DONE when (mplier>>1)==0 or cnt==N-1; otherwise stay in ITER.
- DONE: done=1, product=acc (the product register loads at the edge entering DONE). Go to IDLE unconditionally.
  - alu_* drive the IDLE values.
- busy=1 in CHECK, ITER and DONE.
- Latency: let k = index of the highest set bit of op_b plus 1 (k=0 when op_b=0).
  - done is high in the cycle after edge E(1+k), where E0 is the accepting edge.
  - Next accept is possible at E(3+k) at the earliest.
- Width rules: all arithmetic is modulo 2^N and carries out of bit N-1 are discarded. Two's-complement operands need no special handling.
- start while busy: ignored, no queueing. start held high continuously: a new operation is accepted in the first IDLE cycle.
- op_a/op_b changing after acceptance have no effect.
- alu_result is used only in ITER and alu_zero only in CHECK; both are don't-care elsewhere.

Decomposition:
- Package alu_pkg:
  - ALU control constants ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_PASSB=4'b0111.
  - Enum mul_state_t {IDLE, CHECK, ITER, DONE}.
  - The datapath ALU decoder uses the same constants.
- cnt width is $clog2(N).
- No sub-module. The ALU is instantiated by the parent; the testbench pairs this block with the existing 64-bit ALU.

Test Plan:
- op_a=6, op_b=7, start pulse -> ITER ctrl sequence 0010,0010,0010; done high after E4; product=42; busy low after E5.
- op_a=5, op_b=0 -> CHECK drives ctrl 0000 with alu_zero=1; done after E1; product=0; no ITER cycles.
- op_a=64'hFFFF_FFFF_FFFF_FFFD (-3), op_b=4 -> ctrl sequence 0111,0111,0010; product=64'hFFFF_FFFF_FFFF_FFF4 (-12); done after E4.
- op_a=op_b=64'hFFFF_FFFF_FFFF_FFFF -> 64 ITER cycles, cnt terminates at N-1; done after E65; product=1.
- Accept 3*9, pulse start with op_a=100 during ITER, then drive reset=0 for one cycle mid-ITER:
  - busy, done and product go to 0 immediately (asynchronous), with no done pulse.
  - Next start with 2*3 gives product=6.
- start held high with operands 2*3, then 4*5 -> done pulses with product 6, then 20; second accept occurs in the IDLE cycle after DONE.
